mem_arbiter: RTL and testbench

Shares one single-ported memory between the pipeline's instruction-fetch port and data (memory-stage) port. Sits between the core's fetch/data memory interfaces and the memory model. Each side has a one-deep request slot. A three-state sequencer issues one memory transaction at a time and returns its result to the requester that owns it.

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between a fetch slot and a data slot.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflicts; otherwise data always wins.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_start,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic [2:0]        d_cmd,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  output logic              d_cmd_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              mem_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_wmask,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic i_pend_q, i_pend_d, d_pend_q, d_pend_d, d_we_q, d_we_d, gnt_q, gnt_d, g;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, wmask_q, wmask_d, mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] mem_wmask_q, mem_wmask_d, inst_q, inst_d, rdata_q, rdata_d;
  logic inst_valid_q, inst_valid_d, rdata_valid_q, rdata_valid_d;
  logic mem_start_q, mem_start_d, mem_we_q, mem_we_d;
  logic i_acc, d_acc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
  assign g = (i_pend_q && d_pend_q) ? !last_grant_q : d_pend_q;
`else
  assign g = d_pend_q;
`endif
  assign i_acc = inst_start && !i_pend_q;
  assign d_acc = (d_cmd == 3'd1 || d_cmd == 3'd2) && !d_pend_q;
  assign inst_ready = !i_pend_q;
  assign d_cmd_ready = !d_pend_q;
  assign inst = inst_q;
  assign inst_valid = inst_valid_q;
  assign rdata = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign mem_start = mem_start_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    i_pend_d = i_pend_q;
    i_addr_d = i_acc ? i_addr : i_addr_q;
    d_pend_d = d_pend_q;
    d_we_d = d_acc ? (d_cmd == 3'd2) : d_we_q;
    d_addr_d = d_acc ? d_addr : d_addr_q;
    wdata_d = d_acc ? wdata : wdata_q;
    wmask_d = d_acc ? wmask : wmask_q;
    mem_start_d = mem_start_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    inst_d = inst_q;
    rdata_d = rdata_q;
    inst_valid_d = 1'b0;
    rdata_valid_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    if (i_acc) i_pend_d = 1'b1;
    if (d_acc) d_pend_d = 1'b1;
    case (state_q)
      IDLE: if (i_pend_q || d_pend_q) begin
        state_d = ISSUE;
        gnt_d = g;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = g;
`endif
        mem_start_d = 1'b1;
        mem_we_d = g && d_we_q;
        mem_addr_d = g ? d_addr_q : i_addr_q;
        mem_wdata_d = g ? wdata_q : '0;
        mem_wmask_d = g ? wmask_q : '0;
      end
      ISSUE: if (mem_ready) begin
        mem_start_d = 1'b0;
        state_d = (gnt_q && d_we_q) ? IDLE : WAIT;
        // Writes have no read phase: complete on memory acceptance.
        if (gnt_q && d_we_q) begin
          d_pend_d = 1'b0;
          rdata_valid_d = 1'b1;
          rdata_d = '0;
        end
      end
      WAIT: if (mem_rdata_valid) begin
        state_d = IDLE;
        if (gnt_q) begin
          d_pend_d = 1'b0;
          rdata_valid_d = 1'b1;
          rdata_d = mem_rdata;
        end else begin
          i_pend_d = 1'b0;
          inst_valid_d = 1'b1;
          inst_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      i_pend_q <= 1'b0;
      i_addr_q <= '0;
      d_pend_q <= 1'b0;
      d_we_q <= 1'b0;
      d_addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      mem_start_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      inst_q <= '0;
      rdata_q <= '0;
      inst_valid_q <= 1'b0;
      rdata_valid_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      i_pend_q <= i_pend_d;
      i_addr_q <= i_addr_d;
      d_pend_q <= d_pend_d;
      d_we_q <= d_we_d;
      d_addr_q <= d_addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      mem_start_q <= mem_start_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      inst_q <= inst_d;
      rdata_q <= rdata_d;
      inst_valid_q <= inst_valid_d;
      rdata_valid_q <= rdata_valid_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic inst_start = 1'b0, inst_ready, inst_valid;
  logic [31:0] i_addr = '0, inst;
  logic [2:0] d_cmd = '0;
  logic [31:0] d_addr = '0, wdata = '0, wmask = '0, rdata;
  logic d_cmd_ready, rdata_valid;
  logic mem_start, mem_we, mem_ready = 1'b1, mem_rdata_valid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_wmask, mem_rdata = '0;
  int checks = 0, fails = 0;
  mem_arbiter dut (
    .clk(clk), .rst(rst), .inst_start(inst_start), .i_addr(i_addr), .inst_ready(inst_ready),
    .inst(inst), .inst_valid(inst_valid), .d_cmd(d_cmd), .d_addr(d_addr), .wdata(wdata),
    .wmask(wmask), .d_cmd_ready(d_cmd_ready), .rdata(rdata), .rdata_valid(rdata_valid),
    .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Waits (bounded) for mem_start, accepts it, then returns one read word.
  task automatic serve(input logic [31:0] data, output logic [31:0] addr, output logic ok);
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_start) break;
      step();
    end
    ok = mem_start;
    addr = mem_addr;
    step();
    mem_rdata_valid = 1'b1;
    mem_rdata = data;
    step();
    mem_rdata_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if ({inst_ready, d_cmd_ready} !== 2'b11) begin fails++; $display("FAIL reset_ready got %b want 11", {inst_ready, d_cmd_ready}); end
    checks++; if ({mem_start, mem_we, inst_valid, rdata_valid} !== 4'b0) begin fails++; $display("FAIL reset_ctrl got %b want 0000", {mem_start, mem_we, inst_valid, rdata_valid}); end
    checks++; if ({inst, rdata, mem_addr} !== 96'b0) begin fails++; $display("FAIL reset_data got %h want 0", {inst, rdata, mem_addr}); end
    rst = 1'b0;
    step();
  endtask
  task automatic test_fetch();
    mem_ready = 1'b1;
    inst_start = 1'b1;
    i_addr = 32'h100;
    step();
    inst_start = 1'b0;
    checks++; if ({inst_ready, mem_start} !== 2'b00) begin fails++; $display("FAIL fetch_e0 got %b want 00", {inst_ready, mem_start}); end
    step();
    checks++; if ({mem_start, mem_we, inst_ready} !== 3'b100 || mem_addr !== 32'h100) begin fails++; $display("FAIL fetch_issue got %b addr %h want 100 addr 100", {mem_start, mem_we, inst_ready}, mem_addr); end
    step();
    checks++; if ({mem_start, inst_valid, inst_ready} !== 3'b000) begin fails++; $display("FAIL fetch_wait got %b want 000", {mem_start, inst_valid, inst_ready}); end
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'h13;
    step();
    mem_rdata_valid = 1'b0;
    checks++; if ({inst_valid, inst_ready} !== 2'b11 || inst !== 32'h13) begin fails++; $display("FAIL fetch_done got %b inst %h want 11 inst 13", {inst_valid, inst_ready}, inst); end
    step();
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h13) begin fails++; $display("FAIL fetch_hold got %b inst %h want 0 inst 13", inst_valid, inst); end
  endtask
  task automatic test_conflict();
    logic [31:0] a;
    logic ok;
    logic rr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    inst_start = 1'b1; i_addr = 32'h300;
    d_cmd = 3'd1; d_addr = 32'h400;
    step();
    inst_start = 1'b0; d_cmd = 3'd0;
    serve(32'hA, a, ok);
    checks++; if (!ok || a !== 32'h400 || rdata_valid !== 1'b1 || inst_valid !== 1'b0 || rdata !== 32'hA) begin fails++; $display("FAIL conflict1_first got ok %b addr %h rv %b iv %b rdata %h want addr 400 rdata a", ok, a, rdata_valid, inst_valid, rdata); end
    serve(32'hB, a, ok);
    checks++; if (!ok || a !== 32'h300 || inst_valid !== 1'b1 || inst !== 32'hB) begin fails++; $display("FAIL conflict1_second got ok %b addr %h iv %b inst %h want addr 300 inst b", ok, a, inst_valid, inst); end
    d_cmd = 3'd1; d_addr = 32'h500;
    step();
    d_cmd = 3'd0;
    serve(32'hC, a, ok);
    checks++; if (!ok || a !== 32'h500 || rdata !== 32'hC) begin fails++; $display("FAIL lone_read got ok %b addr %h rdata %h want addr 500 rdata c", ok, a, rdata); end
    inst_start = 1'b1; i_addr = 32'h310;
    d_cmd = 3'd1; d_addr = 32'h410;
    step();
    inst_start = 1'b0; d_cmd = 3'd0;
    serve(32'hD, a, ok);
    checks++; if (!ok || a !== (rr ? 32'h310 : 32'h410)) begin fails++; $display("FAIL conflict2_first got ok %b addr %h want %h", ok, a, rr ? 32'h310 : 32'h410); end
    serve(32'hE, a, ok);
    checks++; if (!ok || a !== (rr ? 32'h410 : 32'h310)) begin fails++; $display("FAIL conflict2_second got ok %b addr %h want %h", ok, a, rr ? 32'h410 : 32'h310); end
    checks++; if (inst !== (rr ? 32'hD : 32'hE) || rdata !== (rr ? 32'hE : 32'hD)) begin fails++; $display("FAIL conflict2_data got inst %h rdata %h", inst, rdata); end
    step();
  endtask
  task automatic test_write_stall();
    mem_ready = 1'b0;
    d_cmd = 3'd2; d_addr = 32'h200; wdata = 32'hDEADBEEF; wmask = 32'hFFFFFFFF;
    step();
    d_cmd = 3'd0;
    checks++; if (d_cmd_ready !== 1'b0) begin fails++; $display("FAIL write_accept got %b want 0", d_cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({mem_start, mem_we, rdata_valid} !== 3'b110 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF || mem_wmask !== 32'hFFFFFFFF) begin
        fails++; $display("FAIL write_hold%0d got %b addr %h wd %h wm %h want 110 200 deadbeef ffffffff", i, {mem_start, mem_we, rdata_valid}, mem_addr, mem_wdata, mem_wmask);
      end
    end
    mem_ready = 1'b1;
    step();
    checks++; if ({rdata_valid, mem_start, d_cmd_ready} !== 3'b101 || rdata !== 32'h0) begin fails++; $display("FAIL write_done got %b rdata %h want 101 rdata 0", {rdata_valid, mem_start, d_cmd_ready}, rdata); end
    step();
    checks++; if (rdata_valid !== 1'b0) begin fails++; $display("FAIL write_pulse got %b want 0", rdata_valid); end
  endtask
  task automatic test_reset_mid();
    mem_ready = 1'b1;
    d_cmd = 3'd1; d_addr = 32'h600;
    step();
    d_cmd = 3'd0;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++; if ({inst_ready, d_cmd_ready, mem_start} !== 3'b110) begin fails++; $display("FAIL reset_async got %b want 110", {inst_ready, d_cmd_ready, mem_start}); end
    step();
    rst = 1'b0;
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'h55;
    step();
    mem_rdata_valid = 1'b0;
    checks++; if ({inst_valid, rdata_valid, mem_start} !== 3'b000 || rdata !== 32'h0) begin fails++; $display("FAIL reset_discard got %b rdata %h want 000 rdata 0", {inst_valid, rdata_valid, mem_start}, rdata); end
    step();
    checks++; if ({inst_ready, d_cmd_ready, mem_start, rdata_valid} !== 4'b1100) begin fails++; $display("FAIL reset_after got %b want 1100", {inst_ready, d_cmd_ready, mem_start, rdata_valid}); end
  endtask
  task automatic test_bad_cmd();
    d_cmd = 3'd5; d_addr = 32'h700;
    step();
    checks++; if (d_cmd_ready !== 1'b1) begin fails++; $display("FAIL badcmd_ready got %b want 1", d_cmd_ready); end
    d_cmd = 3'd3;
    step();
    d_cmd = 3'd0;
    step();
    checks++; if ({mem_start, d_cmd_ready} !== 2'b01) begin fails++; $display("FAIL badcmd_nostart got %b want 01", {mem_start, d_cmd_ready}); end
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_conflict();
    test_write_stall();
    test_reset_mid();
    test_bad_cmd();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
